lamp_pwm_driver: RTL and testbench
==================================

Name: lamp_pwm_driver

Overview:
Reader/consumer side of the lamp state registers: takes a stored brightness level, loaded by a one-cycle enable strobe, and drives the physical lamp pin.
- Ramps the displayed level one step at a time toward the loaded target.
- Renders the displayed level as PWM on a single output.
- Sits between the lamp FSM's level register and the board LED pin.

Parameters:
LVL_W, 4, width of level, target, displayed level and PWM counter.
STEP_DIV, 16, clock cycles per ramp step (>=1).
TIMEOUT, 1000, idle cycles before auto-off (used only with LAMP_AUTO_OFF_EN).

Ports:
clk  input  1  system clock, rising edge.
clr  input  1  asynchronous active-high reset.
en  input  1  load strobe; samples level on a rising clk edge when high.
level  input  LVL_W  requested brightness, 0 = off, 2^LVL_W-1 = full on.
lamp  output  1  registered PWM lamp drive.
cur_level  output  LVL_W  currently displayed level.
busy  output  1  high while ramping (state != IDLE).
done  output  1  one-cycle pulse when cur_level reaches target.

Behaviour:
- Interface: one clock, clk; reset clr is asynchronous and active-high.
- While clr is high, all state clears immediately, with no clk edge needed:
  - cur_level=0, target=0, pwm_cnt=0, div_cnt=0, state=IDLE.
  - lamp=0, busy=0, done=0.
  - Releasing clr mid-ramp leaves the block idle at level 0.
- States:
  - IDLE: cur_level == target.
  - RAMP_UP: cur_level < target.
  - RAMP_DOWN: cur_level > target.
- Load, on a clk edge with en=1:
  - target <= level; div_cnt <= 0.
  - Next state is chosen by comparing level with cur_level after any step applied on the same edge.
  - If they are equal: state=IDLE and done=1 on the next cycle.
- Ramp, in RAMP_UP or RAMP_DOWN without en:
  - div_cnt increments each cycle.
  - When div_cnt == STEP_DIV-1: cur_level moves ±1 and div_cnt <= 0.
  - When the step makes cur_level == target: state <= IDLE and done pulses for exactly one cycle.
- Ramp latency:
  - First step lands STEP_DIV cycles after the load edge.
  - A ramp of N levels completes N*STEP_DIV cycles after the load.
- Simultaneous load and step edge: the step is applied, then target and direction come from the new level. done fires only if the stepped value equals the new level.
- Retarget mid-ramp is allowed:
  - Direction may reverse.
  - div_cnt restarts at 0.
  - No done pulse for the abandoned target.
- cur_level never wraps. It saturates by construction, since a step is taken only toward target.
- PWM:
  - pwm_cnt runs free 0..2^LVL_W-2, then wraps to 0 (period 2^LVL_W-1 cycles).
  - lamp <= (pwm_cnt < cur_level), registered, with one cycle latency from the compare operands.
  - Level 0 gives lamp constantly 0; level 2^LVL_W-1 gives lamp constantly 1.
  - A cur_level change takes effect at the next compare, not at period boundaries; mid-period duty changes are accepted.
- busy is combinational from state: high exactly in RAMP_UP/RAMP_DOWN.
- done and busy are never both asserted on the cycle done pulses.

Optional Feature:
Macro LAMP_AUTO_OFF_EN.
- Defined:
  - An idle counter increments each cycle while state=IDLE, cur_level != 0 and en=0.
  - The counter clears on en, on any ramp, on cur_level=0, and on clr.
  - When it reaches TIMEOUT-1, the block performs an internal load of level 0: target=0, state=RAMP_DOWN, div_cnt=0.
  - The ramp then proceeds and ends with a normal done pulse.
  - An external en on the same edge overrides the internal load.
- Undefined: no idle counter is present, the lamp holds its level indefinitely, and TIMEOUT is ignored.

Test Plan:
1. Reset and idle: assert clr asynchronously mid-ramp (cur_level=7, busy=1) with no clk edge -> lamp, cur_level, busy and done read 0 immediately. After release, with no en for 100 cycles -> all stay 0.
2. Ramp up, LVL_W=4, STEP_DIV=4: en with level=15 at cycle 0 -> cur_level increments at cycles 4, 8, ..., 60. busy=1 over cycles 1-60. done=1 for exactly the one cycle after cur_level reaches 15. lamp is then constantly 1.
3. PWM duty, idle at level 5: over any 15 consecutive cycles -> lamp high exactly 5 cycles. Level 0 -> lamp never high.
4. Retarget mid-ramp: load 12 from 0, then at cur_level=6 load 2 -> direction reverses, next step to 5 lands STEP_DIV cycles after that load, single done when cur_level reaches 2, no done at 12.
5. Equal load: idle at 9, en with level=9 -> busy stays 0, done pulses once on the following cycle, cur_level unchanged.
6. (LAMP_AUTO_OFF_EN, TIMEOUT=50, STEP_DIV=2) Idle at level 3 with no en -> ramp down starts after 50 idle cycles, reaches 0 after 6 more cycles, done pulses once. A repeat run with en at idle cycle 30 restarts the count.

Source files
------------

// File: rtl/lamp_pwm_driver.sv
// lamp_pwm_driver
//   Consumer side of the lamp level register. A one-cycle en strobe loads a
//   target brightness; the displayed level ramps one step every STEP_DIV
//   clocks toward it and is rendered as PWM on the lamp pin.
//
// Ports:
//   clk        system clock, rising edge
//   clr        asynchronous active-high reset
//   en         load strobe, samples level on a rising clk edge
//   level      requested brightness (0 = off, all ones = full on)
//   lamp       registered PWM drive
//   cur_level  currently displayed level
//   busy       high while ramping
//   done       one-cycle pulse when cur_level reaches the target
//
// Optional feature: define LAMP_AUTO_OFF_EN to ramp to 0 after TIMEOUT idle
// cycles at a non-zero level. Undefined, the level is held indefinitely.
module lamp_pwm_driver #(
   parameter int LVL_W    = 4,
   parameter int STEP_DIV = 16,
   parameter int TIMEOUT  = 1000
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic [LVL_W-1:0] level,
   output logic             lamp,
   output logic [LVL_W-1:0] cur_level,
   output logic             busy,
   output logic             done
);

   localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
   localparam logic [LVL_W-1:0] PWM_LAST = LVL_W'((2 ** LVL_W) - 2);

   typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} state_t;

   state_t           state, state_nx;
   logic [LVL_W-1:0] target, target_nx;
   logic [LVL_W-1:0] cur_nx, stepped;
   logic [DIV_W-1:0] div_cnt, div_nx;
   logic [LVL_W-1:0] pwm_cnt;
   logic             done_nx;
   logic             step;
   logic             load;
   logic [LVL_W-1:0] load_lvl;
   logic             auto_fire;

`ifdef LAMP_AUTO_OFF_EN
   localparam int IDL_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [IDL_W-1:0] idle_cnt;
   logic             idle_run;

   assign idle_run  = (state == IDLE) && (cur_level != '0) && !en;
   assign auto_fire = idle_run && (idle_cnt == IDL_W'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge clr) begin
      if (clr)
         idle_cnt <= '0;
      else if (idle_run && !auto_fire)
         idle_cnt <= idle_cnt + 1'b1;
      else
         idle_cnt <= '0;
   end
`else
   assign auto_fire = 1'b0;
`endif

   assign busy = (state != IDLE);

   always_comb begin
      step      = (state != IDLE) && (div_cnt == DIV_LAST);
      stepped   = cur_level;
      if (step) begin
         if (state == RAMP_UP)
            stepped = cur_level + 1'b1;
         else
            stepped = cur_level - 1'b1;
      end

      cur_nx    = stepped;
      target_nx = target;
      div_nx    = div_cnt;
      state_nx  = state;
      done_nx   = 1'b0;
      load      = en;
      load_lvl  = level;

      // internal auto-off load only when no external strobe competes
      if (auto_fire && !en) begin
         load     = 1'b1;
         load_lvl = '0;
      end

      // a load compares against the already-stepped level, so a step landing
      // on the same edge is never lost
      if (load) begin
         target_nx = load_lvl;
         div_nx    = '0;
         if (load_lvl > stepped)
            state_nx = RAMP_UP;
         else if (load_lvl < stepped)
            state_nx = RAMP_DOWN;
         else begin
            state_nx = IDLE;
            done_nx  = 1'b1;
         end
      end else if (state != IDLE) begin
         if (step) begin
            div_nx = '0;
            if (stepped == target) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
            end
         end else begin
            div_nx = div_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state     <= IDLE;
         cur_level <= '0;
         target    <= '0;
         div_cnt   <= '0;
         done      <= 1'b0;
      end else begin
         state     <= state_nx;
         cur_level <= cur_nx;
         target    <= target_nx;
         div_cnt   <= div_nx;
         done      <= done_nx;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         pwm_cnt <= '0;
         lamp    <= 1'b0;
      end else begin
         pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
         lamp    <= (pwm_cnt < cur_level);
      end
   end

endmodule

// File: tb/tb_lamp_pwm_driver.sv
module tb_lamp_pwm_driver;

   localparam int LW  = 4;
   localparam int SD  = 4;
   localparam int PER = 15;

   logic          clk = 1'b0;
   logic          clr;
   logic          en;
   logic [LW-1:0] level;
   logic          lamp;
   logic [LW-1:0] cur_level;
   logic          busy;
   logic          done;

   always #5 clk = ~clk;

   lamp_pwm_driver #(.LVL_W(LW), .STEP_DIV(SD), .TIMEOUT(1000)) dut (
      .clk(clk), .clr(clr), .en(en), .level(level),
      .lamp(lamp), .cur_level(cur_level), .busy(busy), .done(done)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // reference: trajectory from the last load (edge L, start s, goal g)
   int k, L, s, g;
   int cur_m, lamp_m, done_m, busy_m;

   function automatic int traj(input int e);
      int n, d, m;
      n = (g >= s) ? g - s : s - g;
      d = (e - L) / SD;
      m = (d < n) ? d : n;
      return (g >= s) ? s + m : s - m;
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      k = 0; L = -100000; s = 0; g = 0;
      cur_m = 0; lamp_m = 0; done_m = 0; busy_m = 0;
   endtask

   task automatic cyc(input logic e, input int lv);
      int cn, n;
      en    = e;
      level = LW'(lv);
      @(posedge clk);
      lamp_m = ((k % PER) < cur_m) ? 1 : 0;
      k++;
      cn = traj(k);
      if (e) begin
         s = cn; g = lv; L = k;
      end
      n = (g >= s) ? g - s : s - g;
      done_m = ((k - L) == n * SD) ? 1 : 0;
      busy_m = ((k - L) < n * SD) ? 1 : 0;
      cur_m  = cn;
      #1;
      chk("cur_level", int'(cur_level), cur_m);
      chk("lamp", int'(lamp), lamp_m);
      chk("done", int'(done), done_m);
      chk("busy", int'(busy), busy_m);
      en = 1'b0;
   endtask

   initial begin
      int hi, nd;
      clr = 1'b1; en = 1'b0; level = '0;
      model_reset();
      #3;
      chk("rst_cur", int'(cur_level), 0);
      chk("rst_lamp", int'(lamp), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      #9 clr = 1'b0;

      // async clear mid-ramp
      cyc(1'b1, 15);
      repeat (28) cyc(1'b0, 0);
      chk("mid_cur7", int'(cur_level), 7);
      chk("mid_busy", int'(busy), 1);
      #2 clr = 1'b1;
      #1;
      chk("aclr_cur", int'(cur_level), 0);
      chk("aclr_lamp", int'(lamp), 0);
      chk("aclr_busy", int'(busy), 0);
      chk("aclr_done", int'(done), 0);
      #10;
      clr = 1'b0;
      model_reset();
      repeat (100) cyc(1'b0, 0);

      // full ramp 0 -> 15
      nd = 0;
      cyc(1'b1, 15);
      repeat (65) begin
         cyc(1'b0, 0);
         nd += int'(done);
      end
      chk("up_done_cnt", nd, 1);
      hi = 0;
      repeat (PER) begin
         cyc(1'b0, 0);
         hi += int'(lamp);
      end
      chk("duty15", hi, 15);

      // duty at 5 and at 0
      cyc(1'b1, 5);
      repeat (50) cyc(1'b0, 0);
      hi = 0;
      repeat (PER) begin
         cyc(1'b0, 0);
         hi += int'(lamp);
      end
      chk("duty5", hi, 5);
      cyc(1'b1, 0);
      repeat (25) cyc(1'b0, 0);
      hi = 0;
      repeat (PER) begin
         cyc(1'b0, 0);
         hi += int'(lamp);
      end
      chk("duty0", hi, 0);

      // retarget mid-ramp with reversal
      cyc(1'b1, 12);
      repeat (24) cyc(1'b0, 0);
      chk("rt_cur6", int'(cur_level), 6);
      cyc(1'b1, 2);
      repeat (3) cyc(1'b0, 0);
      chk("rt_hold6", int'(cur_level), 6);
      cyc(1'b0, 0);
      chk("rt_step5", int'(cur_level), 5);
      nd = 0;
      repeat (20) begin
         cyc(1'b0, 0);
         nd += int'(done);
      end
      chk("rt_done_cnt", nd, 1);
      chk("rt_cur2", int'(cur_level), 2);

      // equal load
      cyc(1'b1, 9);
      repeat (32) cyc(1'b0, 0);
      cyc(1'b1, 9);
      chk("eq_done", int'(done), 1);
      chk("eq_busy", int'(busy), 0);
      chk("eq_cur", int'(cur_level), 9);
      cyc(1'b0, 0);
      chk("eq_done_off", int'(done), 0);

      // load landing on a step edge whose stepped value matches
      cyc(1'b1, 14);
      repeat (3) cyc(1'b0, 0);
      cyc(1'b1, 10);
      chk("coinc_done", int'(done), 1);
      chk("coinc_cur", int'(cur_level), 10);

      // randomized loads
      repeat (800) cyc($urandom_range(0, 9) == 0, int'($urandom_range(0, 15)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
